// File: rtl/i2c_regs_pkg.sv
// i2c_regs_pkg: shared constants for the I2C register block.
// Contents: register index constants, CTRL/STATUS/INT_STAT bit positions,
// and the PRESCALE reset value.
package i2c_regs_pkg;

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_PRESCALE = 3'd1;
  localparam logic [2:0] REG_TXDATA   = 3'd2;
  localparam logic [2:0] REG_RXDATA   = 3'd3;
  localparam logic [2:0] REG_STATUS   = 3'd4;
  localparam logic [2:0] REG_INT_STAT = 3'd5;
  localparam logic [2:0] REG_INT_MASK = 3'd6;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_TX_FLUSH = 1;
  localparam int CTRL_RX_FLUSH = 2;

  localparam int STAT_TX_EMPTY  = 0;
  localparam int STAT_TX_FULL   = 1;
  localparam int STAT_RX_EMPTY  = 2;
  localparam int STAT_RX_FULL   = 3;
  localparam int STAT_CORE_BUSY = 4;
  localparam int STAT_TX_LVL    = 8;
  localparam int STAT_RX_LVL    = 12;

  localparam int INT_NACK     = 0;
  localparam int INT_ARB_LOST = 1;
  localparam int INT_TX_OVF   = 2;
  localparam int INT_RX_OVF   = 3;

  localparam logic [15:0] PRESCALE_RST = 16'h00FF;

endpackage

// File: rtl/i2c_sync_fifo.sv
// i2c_sync_fifo: 8-bit synchronous FIFO with flush.
// Ports: pclk/presetn clock and async active-low reset; push/din write side;
//        pop/dout read side (dout is the current head); flush empties the FIFO;
//        full/empty/level status; overflow pulses when a push is dropped.
// DEPTH must be a power of two (2, 4 or 8) so the pointers wrap naturally.
module i2c_sync_fifo
  import i2c_regs_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     pclk,
  input  logic                     presetn,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  input  logic                     flush,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_MAX = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full  = (level == LVL_MAX);
  assign empty = (level == '0);
  assign dout  = mem[rd_ptr];

  // A pop on a full FIFO frees the slot the concurrent push lands in.
  // Flush beats both and suppresses the overflow event.
  assign do_pop   = pop && !empty && !flush;
  assign do_push  = push && (!full || do_pop) && !flush;
  assign overflow = push && full && !do_pop && !flush;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/i2c_regs.sv
// i2c_regs: register file between the bus interface unit and the I2C core.
// Bus side:  wr_en/rd_en strobes, reg_addr, byte_en, ipwdata, iprdata (comb).
// Core side: core_en, prescale, TX FIFO head (tx_data/tx_valid/tx_pop),
//            RX FIFO input (rx_data/rx_push/rx_full), core_busy, event pulses,
//            registered intr.
// Build option: define I2C_REGS_INTR_EN to include INT_STAT/INT_MASK and intr;
// without it those registers read 0, events are dropped and intr is 0.
module i2c_regs
  import i2c_regs_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [2:0]  reg_addr,
  input  logic [3:0]  byte_en,
  input  logic [31:0] ipwdata,
  output logic [15:0] iprdata,
  output logic        core_en,
  output logic [15:0] prescale,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_pop,
  input  logic [7:0]  rx_data,
  input  logic        rx_push,
  output logic        rx_full,
  input  logic        core_busy,
  input  logic        ev_nack,
  input  logic        ev_arb_lost,
  output logic        intr
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          wr_ctrl, wr_pre, wr_tx;
  logic          tx_flush, rx_flush, rx_pop;
  logic          tx_empty, tx_full, rx_empty;
  logic          tx_ovf, rx_ovf;
  logic [LW-1:0] tx_level, rx_level;
  logic [7:0]    rx_head;
  logic [15:0]   status;
  logic [3:0]    int_stat, int_mask;
  logic          unused_bus;

  assign wr_ctrl  = wr_en && (reg_addr == REG_CTRL) && byte_en[0];
  assign wr_pre   = wr_en && (reg_addr == REG_PRESCALE);
  assign wr_tx    = wr_en && (reg_addr == REG_TXDATA) && byte_en[0];
  assign tx_flush = wr_ctrl && ipwdata[CTRL_TX_FLUSH];
  assign rx_flush = wr_ctrl && ipwdata[CTRL_RX_FLUSH];
  assign rx_pop   = rd_en && (reg_addr == REG_RXDATA);
  assign tx_valid = !tx_empty;

  assign unused_bus = ^{ipwdata[31:16], byte_en[3:2]};

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      core_en  <= 1'b0;
      prescale <= PRESCALE_RST;
    end else begin
      if (wr_ctrl)               core_en        <= ipwdata[CTRL_EN];
      if (wr_pre && byte_en[0])  prescale[7:0]  <= ipwdata[7:0];
      if (wr_pre && byte_en[1])  prescale[15:8] <= ipwdata[15:8];
    end
  end

  i2c_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .pclk     (pclk),
    .presetn  (presetn),
    .push     (wr_tx),
    .din      (ipwdata[7:0]),
    .pop      (tx_pop),
    .flush    (tx_flush),
    .dout     (tx_data),
    .full     (tx_full),
    .empty    (tx_empty),
    .level    (tx_level),
    .overflow (tx_ovf)
  );

  i2c_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .pclk     (pclk),
    .presetn  (presetn),
    .push     (rx_push),
    .din      (rx_data),
    .pop      (rx_pop),
    .flush    (rx_flush),
    .dout     (rx_head),
    .full     (rx_full),
    .empty    (rx_empty),
    .level    (rx_level),
    .overflow (rx_ovf)
  );

`ifdef I2C_REGS_INTR_EN
  logic [3:0] int_evt, int_w1c;

  assign int_evt = {rx_ovf, tx_ovf, ev_arb_lost, ev_nack};
  assign int_w1c = (wr_en && (reg_addr == REG_INT_STAT) && byte_en[0]) ? ipwdata[3:0] : 4'h0;

  // Set has priority over clear so a same-cycle event is never lost.
  // intr is computed from the registered INT_STAT, giving one cycle of latency.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      int_stat <= 4'h0;
      int_mask <= 4'h0;
      intr     <= 1'b0;
    end else begin
      int_stat <= (int_stat & ~int_w1c) | int_evt;
      if (wr_en && (reg_addr == REG_INT_MASK) && byte_en[0]) int_mask <= ipwdata[3:0];
      intr <= |(int_stat & int_mask);
    end
  end
`else
  logic unused_evt;

  assign unused_evt = ^{ev_nack, ev_arb_lost, tx_ovf, rx_ovf};
  assign int_stat   = 4'h0;
  assign int_mask   = 4'h0;
  assign intr       = 1'b0;
`endif

  always_comb begin
    status                       = 16'h0000;
    status[STAT_TX_EMPTY]        = tx_empty;
    status[STAT_TX_FULL]         = tx_full;
    status[STAT_RX_EMPTY]        = rx_empty;
    status[STAT_RX_FULL]         = rx_full;
    status[STAT_CORE_BUSY]       = core_busy;
    status[STAT_TX_LVL +: 4]     = 4'(tx_level);
    status[STAT_RX_LVL +: 4]     = 4'(rx_level);
  end

  always_comb begin
    iprdata = 16'h0000;
    case (reg_addr)
      REG_CTRL:     iprdata = {15'h0000, core_en};
      REG_PRESCALE: iprdata = prescale;
      REG_RXDATA:   iprdata = rx_empty ? 16'h0000 : {8'h00, rx_head};
      REG_STATUS:   iprdata = status;
      REG_INT_STAT: iprdata = {12'h000, int_stat};
      REG_INT_MASK: iprdata = {12'h000, int_mask};
      default:      iprdata = 16'h0000;
    endcase
  end

endmodule

// File: tb/tb_i2c_regs.sv
module tb_i2c_regs;

`ifdef I2C_REGS_INTR_EN
  localparam bit INTR = 1'b1;
`else
  localparam bit INTR = 1'b0;
`endif

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [2:0]  reg_addr = 3'd0;
  logic [3:0]  byte_en = 4'h0;
  logic [31:0] ipwdata = 32'h0;
  logic [15:0] iprdata;
  logic        core_en;
  logic [15:0] prescale;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_pop = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_push = 1'b0;
  logic        rx_full;
  logic        core_busy = 1'b0;
  logic        ev_nack = 1'b0, ev_arb_lost = 1'b0;
  logic        intr;
  logic        samp = 1'b0;

  i2c_regs #(.FIFO_DEPTH(4)) dut (
    .pclk(pclk), .presetn(presetn), .wr_en(wr_en), .rd_en(rd_en),
    .reg_addr(reg_addr), .byte_en(byte_en), .ipwdata(ipwdata), .iprdata(iprdata),
    .core_en(core_en), .prescale(prescale), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_pop(tx_pop), .rx_data(rx_data), .rx_push(rx_push), .rx_full(rx_full),
    .core_busy(core_busy), .ev_nack(ev_nack), .ev_arb_lost(ev_arb_lost), .intr(intr)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    string       nm;
    logic [15:0] exp;
  } rd_exp_t;

  rd_exp_t    rd_q[$];
  logic [7:0] pop_q[$];
  logic [3:0] pr_q[$];   // {rx_full, tx_valid, core_en, intr}

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Monitor: compares whenever the DUT presents data on a strobe.
  always @(negedge pclk) begin
    rd_exp_t e;
    logic [7:0] b;
    logic [3:0] p;
    if (rd_en) begin
      if (rd_q.size() == 0) chk("rd_unexpected", iprdata, 16'hxxxx);
      else begin
        e = rd_q.pop_front();
        chk(e.nm, iprdata, e.exp);
      end
    end
    if (tx_pop && tx_valid) begin
      if (pop_q.size() == 0) chk("txpop_unexpected", {8'h00, tx_data}, 16'hxxxx);
      else begin
        b = pop_q.pop_front();
        chk("tx_pop_data", {8'h00, tx_data}, {8'h00, b});
      end
    end
    if (samp) begin
      if (pr_q.size() == 0) chk("probe_unexpected", 16'h0, 16'hxxxx);
      else begin
        p = pr_q.pop_front();
        chk("probe_flags", {12'h000, rx_full, tx_valid, core_en, intr}, {12'h000, p});
      end
    end
  end

  task automatic cyc();
    @(posedge pclk);
    #1;
    wr_en = 0; rd_en = 0; tx_pop = 0; rx_push = 0;
    ev_nack = 0; ev_arb_lost = 0; samp = 0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1; reg_addr = a; ipwdata = d; byte_en = be;
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string nm);
    rd_exp_t e;
    e.nm = nm; e.exp = exp;
    rd_q.push_back(e);
    rd_en = 1; reg_addr = a;
  endtask

  task automatic probe(input logic [3:0] exp);
    pr_q.push_back(exp);
    samp = 1;
  endtask

  task automatic txpop(input logic [7:0] exp);
    pop_q.push_back(exp);
    tx_pop = 1;
  endtask

  task automatic rxpush(input logic [7:0] d);
    rx_data = d; rx_push = 1;
  endtask

  task automatic do_reset();
    #2 presetn = 0;
    #10 presetn = 1;
    cyc();
  endtask

  task automatic reset_reads(input string tag);
    logic [15:0] rst_exp [8];
    rst_exp = '{16'h0000, 16'h00FF, 16'h0000, 16'h0000, 16'h0005, 16'h0000, 16'h0000, 16'h0000};
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), rst_exp[i], $sformatf("%s_reg%0d", tag, i));
      if (i == 0) probe(4'b0000);
      cyc();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #23 presetn = 1;
    cyc();

    reset_reads("rst");

    wr(3'd7, 32'hFFFF_FFFF, 4'hF); cyc();
    rd(3'd7, 16'h0000, "reserved_wr"); cyc();
    wr(3'd1, 32'hDEAD_1234, 4'hF); cyc();
    rd(3'd1, 16'h1234, "prescale_wr"); cyc();
    wr(3'd1, 32'h0000_AB00, 4'b0010); cyc();
    rd(3'd1, 16'hAB34, "prescale_lane1"); cyc();
    wr(3'd1, 32'hFFFF_FFFF, 4'b1100); cyc();
    rd(3'd1, 16'hAB34, "prescale_lane32"); cyc();
    wr(3'd0, 32'h1, 4'hF); cyc();
    rd(3'd0, 16'h0001, "ctrl_en"); probe(4'b0010); cyc();
    wr(3'd0, 32'h7, 4'hF); cyc();
    rd(3'd0, 16'h0001, "ctrl_flush_rd0"); cyc();
    wr(3'd6, 32'hF, 4'hF); cyc();
    rd(3'd6, INTR ? 16'h000F : 16'h0000, "int_mask_rw"); cyc();
    wr(3'd6, 32'h0, 4'hF); cyc();

    // TX fill and overflow
    for (int i = 0; i < 4; i++) begin
      wr(3'd2, 32'hA1 + i, 4'hF); cyc();
    end
    wr(3'd2, 32'hA5, 4'hF); cyc();
    rd(3'd4, 16'h0406, "tx_full_status"); probe(4'b0110); cyc();
    rd(3'd5, INTR ? 16'h0004 : 16'h0000, "tx_ovf_int"); cyc();
    wr(3'd5, 32'hF, 4'hF); cyc();
    rd(3'd5, 16'h0000, "int_w1c"); cyc();
    rd(3'd2, 16'h0000, "txdata_read0"); cyc();
    for (int i = 0; i < 4; i++) begin
      txpop(8'hA1 + 8'(i)); cyc();
    end
    rd(3'd4, 16'h0005, "tx_drained"); probe(4'b0010); cyc();
    tx_pop = 1; cyc();
    rd(3'd4, 16'h0005, "tx_pop_empty"); cyc();
    wr(3'd2, 32'hEE, 4'b0010); cyc();
    rd(3'd4, 16'h0005, "tx_be0_nopush"); cyc();

    // RX path
    rxpush(8'h3C); cyc();
    rxpush(8'h7E); cyc();
    rd(3'd4, 16'h2001, "rx_lvl2_status"); cyc();
    rd(3'd3, 16'h003C, "rx_rd1"); cyc();
    rd(3'd3, 16'h007E, "rx_rd2"); cyc();
    rd(3'd3, 16'h0000, "rx_rd_empty"); cyc();
    rd(3'd4, 16'h0005, "rx_lvl0_status"); cyc();
    rxpush(8'h11); cyc();
    rxpush(8'h22); cyc();
    rxpush(8'h33); cyc();
    rxpush(8'h44); cyc();
    rxpush(8'h55); cyc();
    rd(3'd4, 16'h4009, "rx_full_status"); probe(4'b1010); cyc();
    rd(3'd5, INTR ? 16'h0008 : 16'h0000, "rx_ovf_int"); cyc();
    wr(3'd5, 32'hF, 4'hF); cyc();
    rd(3'd3, 16'h0011, "rx_pop_push_full"); rxpush(8'h66); cyc();
    rd(3'd4, 16'h4009, "rx_full_kept"); cyc();
    rd(3'd5, 16'h0000, "rx_no_ovf_popush"); cyc();
    wr(3'd0, 32'h5, 4'hF); rxpush(8'h77); cyc();
    rd(3'd4, 16'h0005, "rx_flush_wins"); cyc();
    rd(3'd5, 16'h0000, "rx_flush_no_ovf"); cyc();

    // TX full with simultaneous pop and push, then flush
    for (int i = 0; i < 4; i++) begin
      wr(3'd2, 32'hA1 + i, 4'hF); cyc();
    end
    txpop(8'hA1); wr(3'd2, 32'hB5, 4'hF); cyc();
    rd(3'd4, 16'h0406, "tx_popush_full"); cyc();
    rd(3'd5, 16'h0000, "tx_no_ovf_popush"); cyc();
    txpop(8'hA2); cyc();
    rd(3'd4, 16'h0304, "tx_lvl3"); cyc();
    wr(3'd0, 32'h3, 4'hF); cyc();
    rd(3'd4, 16'h0005, "tx_flush"); probe(4'b0010); cyc();

    // Interrupts
    wr(3'd6, 32'h1, 4'hF); cyc();
    ev_nack = 1; cyc();
    rd(3'd5, INTR ? 16'h0001 : 16'h0000, "nack_set"); probe(4'b0010); cyc();
    probe({3'b001, INTR}); cyc();
    wr(3'd5, 32'h1, 4'hF); cyc();
    probe({3'b001, INTR}); cyc();
    rd(3'd5, 16'h0000, "nack_cleared"); probe(4'b0010); cyc();
    wr(3'd5, 32'h1, 4'hF); ev_nack = 1; cyc();
    rd(3'd5, INTR ? 16'h0001 : 16'h0000, "w1c_vs_set"); cyc();
    wr(3'd5, 32'hF, 4'hF); cyc();
    wr(3'd6, 32'h0, 4'hF); cyc();
    ev_arb_lost = 1; cyc();
    rd(3'd5, INTR ? 16'h0002 : 16'h0000, "arb_lost_set"); cyc();
    probe(4'b0010); cyc();

    // Reset with both FIFOs partly full and intr pending
    wr(3'd2, 32'hC1, 4'hF); cyc();
    wr(3'd2, 32'hC2, 4'hF); cyc();
    rxpush(8'hD1); wr(3'd6, 32'h2, 4'hF); cyc();
    rd(3'd4, 16'h1200, "pre_reset_status"); cyc();
    probe({3'b011, INTR}); cyc();
    do_reset();
    reset_reads("post_rst");

    chk("queues_drained", 16'(rd_q.size() + pop_q.size() + pr_q.size()), 16'h0000);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
